fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
Core-side initiator for fpu_core. It accepts FP requests from the issue pipeline over a valid/ready handshake and drives the FPU operand, command, rounding-mode, Enable and Stall inputs. It holds those inputs stable across the prenorm-register cycle and the normalizer cycle, then captures Result and flags into a response register returned over valid/ready. It also keeps the sticky fflags accumulator (NV,DZ,OF,UF,NX) read by the CSR file.

Parameters:
TAG_WIDTH, 4, width of the request tag passed through unchanged to the response

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  reset, synchronous, active-low
Req_Valid_SI  in  1  request valid
Req_Ready_SO  out  1  request accepted when Valid&Ready
Req_Op_SI  in  C_CMD  command (C_FPU_*_CMD)
Req_RM_SI  in  C_RM  rounding mode
Req_A_DI  in  C_OP  operand a
Req_B_DI  in  C_OP  operand b
Req_Tag_DI  in  TAG_WIDTH  request tag
Resp_Valid_SO  out  1  response valid
Resp_Ready_SI  in  1  response consumed when Valid&Ready
Resp_Result_DO  out  C_OP  result
Resp_Flags_DO  out  6  {IV,OF,UF,IX,Inf,Zero}
Resp_Tag_DO  out  TAG_WIDTH  echoed tag
Flush_SI  in  1  abort in-flight op, drop pending response
Flags_Clr_SI  in  1  clear sticky flags
Fflags_DO  out  5  sticky {NV,DZ,OF,UF,NX}
Fpu_Enable_SO  out  1  to fpu_core Enable_SI
Fpu_Stall_SO  out  1  to fpu_core Stall_SI
Fpu_Op_SO  out  C_CMD  to OP_SI
Fpu_RM_SO  out  C_RM  to RM_SI
Fpu_A_DO  out  C_OP  to Operand_a_DI
Fpu_B_DO  out  C_OP  to Operand_b_DI
Fpu_Result_DI  in  C_OP  from Result_DO
Fpu_Flags_DI  in  6  {IV,OF,UF,IX,Inf,Zero} from fpu_core flag outputs

Behaviour:
- Reset (Rst_RBI=0 at a clock edge): FSM=IDLE; all request, response and sticky registers = 0; Resp_Valid_SO=0; Fpu_Enable_SO=0; Fpu_Stall_SO=1. Any op in flight at reset is dropped.
- Fpu_Op/RM/A/B_DO are driven directly from the request registers.
- FSM states: IDLE, ISSUE, NORM, RESP.
- IDLE: Req_Ready_SO=1, Enable=0, Stall=1.
  - On accept: latch op, rm, a, b, tag.
  - Legal op (ADD, SUB, MUL, I2F, F2I) -> ISSUE.
  - Illegal op -> RESP with Result=0, Flags={IV=1, rest 0}. The FPU is not enabled.
- ISSUE: Enable=1, Stall=0, so the fpu_core prenorm register captures at the end of this cycle.
  - F2I: capture Fpu_Result/Flags at the end of the cycle -> RESP.
  - Otherwise -> NORM.
- NORM: Enable=1, Stall=1; inputs held. Capture Fpu_Result/Flags at the end of the cycle -> RESP.
- RESP: Resp_Valid_SO=1; result, flags and tag stay stable until Resp_Ready_SI=1.
  - Req_Ready_SO = Resp_Ready_SI (back-to-back).
  - On consume with a new accept in the same cycle: go directly to ISSUE (or RESP for an illegal op).
  - On consume without a new accept -> IDLE.
- Latency from accept cycle T: Resp_Valid at T+3 for ADD/SUB/MUL/I2F, T+2 for F2I, T+1 for illegal op.
- Throughput: one op per 3 cycles (arithmetic) with Resp_Ready tied high.
- Sticky flags:
  - Update on every capture into RESP: NV|=IV, OF|=OF, UF|=UF, NX|=IX. DZ is always 0 (no divider).
  - Flags_Clr_SI coinciding with a capture: result = new flags only (clear then set).
  - Flags_Clr_SI alone: all bits 0 the next cycle.
- Flush_SI:
  - Next state IDLE from any state; the pending or in-flight result is discarded with no sticky update.
  - Req_Ready_SO=0 while Flush_SI=1, so flush wins over a simultaneous request.
  - Resp_Valid_SO=0 the cycle after the flush.
- Enable is never asserted outside ISSUE/NORM.

Decomposition:
- Package fpu_defs:
  - existing C_OP, C_RM, C_CMD and C_FPU_*_CMD;
  - add a state enum typedef for IDLE/ISSUE/NORM/RESP;
  - add index constants for the 6-bit flag vector and the 5-bit fflags vector.
- One natural sub-module: fpu_fflags_acc, the sticky accumulator with clear/set priority.

Test Plan:
1. ADD a=0x3F800000, b=0x40000000, RM=0, tag=5, Resp_Ready=1 -> Result 0x40400000, Flags 0, tag 5; Resp_Valid exactly at T+3; Stall=0 only in T+1.
2. F2I a=0x40490FDB, RM=RTZ -> Result 0x00000003, IX=1 at T+2; Fflags NX=1.
3. MUL 0x7F000000×0x7F000000 with Resp_Ready=0 for 5 cycles -> Result 0x7F800000, OF=IX=1 held stable; Req_Ready=0 throughout. Assert Flags_Clr_SI in the capture cycle -> Fflags = OF|NX only.
4. Illegal op code -> Result 0, IV=1 at T+1; Fpu_Enable never asserted; Fflags NV=1.
5. Assert Flush_SI during NORM, then issue SUB 0x40400000−0x3F800000 -> no response for the flushed op; SUB returns 0x40000000; sticky flags unchanged by the flushed op.
6. Drive Rst_RBI=0 for one cycle during ISSUE -> next cycle Resp_Valid=0, Fflags=0, Stall=1, Enable=0; Rst_RBI edges between clocks have no effect until the next edge.

Source files
------------

// File: rtl/fpu_defs.sv
// Shared FPU encodings: operand/command/rounding widths, command codes, flag indices.
// Pure definitions, no logic and no latency.
// No handshake of its own; imported by every block that talks to fpu_core.
package fpu_defs;

    localparam int C_OP  = 32;
    localparam int C_RM  = 3;
    localparam int C_CMD = 4;

    localparam logic [C_RM-1:0] C_RM_NEAREST  = 3'h0;
    localparam logic [C_RM-1:0] C_RM_TRUNC    = 3'h1;
    localparam logic [C_RM-1:0] C_RM_MINUSINF = 3'h2;
    localparam logic [C_RM-1:0] C_RM_PLUSINF  = 3'h3;

    localparam logic [C_CMD-1:0] C_FPU_ADD_CMD    = 4'h0;
    localparam logic [C_CMD-1:0] C_FPU_SUB_CMD    = 4'h1;
    localparam logic [C_CMD-1:0] C_FPU_MUL_CMD    = 4'h2;
    localparam logic [C_CMD-1:0] C_FPU_DIV_CMD    = 4'h3;
    localparam logic [C_CMD-1:0] C_FPU_I2F_CMD    = 4'h4;
    localparam logic [C_CMD-1:0] C_FPU_F2I_CMD    = 4'h5;
    localparam logic [C_CMD-1:0] C_FPU_SQRT_CMD   = 4'h6;
    localparam logic [C_CMD-1:0] C_FPU_NOP_CMD    = 4'h7;
    localparam logic [C_CMD-1:0] C_FPU_FMADD_CMD  = 4'h8;
    localparam logic [C_CMD-1:0] C_FPU_FMSUB_CMD  = 4'h9;
    localparam logic [C_CMD-1:0] C_FPU_FNMADD_CMD = 4'hA;
    localparam logic [C_CMD-1:0] C_FPU_FNMSUB_CMD = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_NORM  = 2'd2,
        ST_RESP  = 2'd3
    } issue_state_e;

    // 6-bit fpu_core flag vector {IV,OF,UF,IX,Inf,Zero}
    localparam int FLG_ZERO = 0;
    localparam int FLG_INF  = 1;
    localparam int FLG_IX   = 2;
    localparam int FLG_UF   = 3;
    localparam int FLG_OF   = 4;
    localparam int FLG_IV   = 5;

    // 5-bit RISC-V fflags vector {NV,DZ,OF,UF,NX}
    localparam int FF_NX = 0;
    localparam int FF_UF = 1;
    localparam int FF_OF = 2;
    localparam int FF_DZ = 3;
    localparam int FF_NV = 4;

    // Only the ops this core's fpu_core actually implements.
    function automatic logic op_is_legal(input logic [C_CMD-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            C_FPU_ADD_CMD, C_FPU_SUB_CMD, C_FPU_MUL_CMD,
            C_FPU_I2F_CMD, C_FPU_F2I_CMD: legal = 1'b1;
            default:                      legal = 1'b0;
        endcase
        return legal;
    endfunction

    // There is no divider, so DZ can never be raised.
    function automatic logic [4:0] flags_to_fflags(input logic [5:0] flg);
        logic [4:0] ff;
        ff        = '0;
        ff[FF_NV] = flg[FLG_IV];
        ff[FF_DZ] = 1'b0;
        ff[FF_OF] = flg[FLG_OF];
        ff[FF_UF] = flg[FLG_UF];
        ff[FF_NX] = flg[FLG_IX];
        return ff;
    endfunction

endpackage

// File: rtl/fpu_fflags_acc.sv
// Sticky fflags accumulator; clear has priority but a same-cycle set survives it.
// Update visible one cycle after Set_Valid_SI / Clr_SI.
// No backpressure: every presented set or clear is absorbed immediately.
module fpu_fflags_acc
    import fpu_defs::*;
(
    input  logic       Clk_CI,
    input  logic       Rst_RBI,
    input  logic       Set_Valid_SI,
    input  logic [4:0] Set_Fflags_DI,
    input  logic       Clr_SI,
    output logic [4:0] Fflags_DO
);

    logic [4:0] fflags_q, fflags_d, set_vec;

    // Clear first, then OR in whatever is being captured this cycle.
    always_comb begin
        set_vec  = Set_Valid_SI ? Set_Fflags_DI : 5'b0;
        fflags_d = Clr_SI ? set_vec : (fflags_q | set_vec);
    end

    // Sticky register with synchronous active-low reset.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) fflags_q <= '0;
        else          fflags_q <= fflags_d;
    end

    assign Fflags_DO = fflags_q;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue-side controller for fpu_core: request reg -> ISSUE -> NORM -> response reg.
// Resp_Valid at T+3 (arith), T+2 (F2I), T+1 (illegal op) after the accept cycle T.
// One op in flight; Req_Ready only in IDLE or when the held response is consumed.
module fpu_issue_ctrl
    import fpu_defs::*;
#(
    parameter int TAG_WIDTH = 4
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RBI,
    input  logic                 Req_Valid_SI,
    output logic                 Req_Ready_SO,
    input  logic [C_CMD-1:0]     Req_Op_SI,
    input  logic [C_RM-1:0]      Req_RM_SI,
    input  logic [C_OP-1:0]      Req_A_DI,
    input  logic [C_OP-1:0]      Req_B_DI,
    input  logic [TAG_WIDTH-1:0] Req_Tag_DI,
    output logic                 Resp_Valid_SO,
    input  logic                 Resp_Ready_SI,
    output logic [C_OP-1:0]      Resp_Result_DO,
    output logic [5:0]           Resp_Flags_DO,
    output logic [TAG_WIDTH-1:0] Resp_Tag_DO,
    input  logic                 Flush_SI,
    input  logic                 Flags_Clr_SI,
    output logic [4:0]           Fflags_DO,
    output logic                 Fpu_Enable_SO,
    output logic                 Fpu_Stall_SO,
    output logic [C_CMD-1:0]     Fpu_Op_SO,
    output logic [C_RM-1:0]      Fpu_RM_SO,
    output logic [C_OP-1:0]      Fpu_A_DO,
    output logic [C_OP-1:0]      Fpu_B_DO,
    input  logic [C_OP-1:0]      Fpu_Result_DI,
    input  logic [5:0]           Fpu_Flags_DI
);

    issue_state_e         state_q, state_d;
    logic [C_CMD-1:0]     op_q;
    logic [C_RM-1:0]      rm_q;
    logic [C_OP-1:0]      a_q, b_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [C_OP-1:0]      res_q, res_d;
    logic [5:0]           flg_q, flg_d;

    logic req_rdy, accept, req_legal, cap_fpu, cap_ill, cap_any;

    assign req_legal = op_is_legal(Req_Op_SI);

    // Next state and FPU/handshake controls; flush overrides everything.
    always_comb begin
        state_d       = state_q;
        req_rdy       = 1'b0;
        Fpu_Enable_SO = 1'b0;
        Fpu_Stall_SO  = 1'b1;
        Resp_Valid_SO = 1'b0;
        cap_fpu       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_rdy = !Flush_SI;
                if (Req_Valid_SI && req_rdy)
                    state_d = req_legal ? ST_ISSUE : ST_RESP;
            end
            ST_ISSUE: begin
                Fpu_Enable_SO = 1'b1;
                Fpu_Stall_SO  = 1'b0;
                if (op_q == C_FPU_F2I_CMD) begin
                    cap_fpu = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                Fpu_Enable_SO = 1'b1;
                cap_fpu       = 1'b1;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                Resp_Valid_SO = 1'b1;
                req_rdy       = Resp_Ready_SI && !Flush_SI;
                if (Resp_Ready_SI) begin
                    if (Req_Valid_SI && req_rdy)
                        state_d = req_legal ? ST_ISSUE : ST_RESP;
                    else
                        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (Flush_SI) begin
            state_d = ST_IDLE;
            cap_fpu = 1'b0;
        end
    end

    assign accept  = Req_Valid_SI && req_rdy;
    assign cap_ill = accept && !req_legal;
    assign cap_any = cap_fpu || cap_ill;

    // Response payload: illegal ops are answered locally with IV and a zero result.
    always_comb begin
        res_d = res_q;
        flg_d = flg_q;
        if (cap_ill) begin
            res_d         = '0;
            flg_d         = '0;
            flg_d[FLG_IV] = 1'b1;
        end else if (cap_fpu) begin
            res_d = Fpu_Result_DI;
            flg_d = Fpu_Flags_DI;
        end
    end

    // State, request and response registers.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            rm_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            if (accept) begin
                op_q  <= Req_Op_SI;
                rm_q  <= Req_RM_SI;
                a_q   <= Req_A_DI;
                b_q   <= Req_B_DI;
                tag_q <= Req_Tag_DI;
            end
        end
    end

    fpu_fflags_acc u_fflags (
        .Clk_CI        (Clk_CI),
        .Rst_RBI       (Rst_RBI),
        .Set_Valid_SI  (cap_any),
        .Set_Fflags_DI (flags_to_fflags(flg_d)),
        .Clr_SI        (Flags_Clr_SI),
        .Fflags_DO     (Fflags_DO)
    );

    assign Req_Ready_SO   = req_rdy;
    assign Fpu_Op_SO      = op_q;
    assign Fpu_RM_SO      = rm_q;
    assign Fpu_A_DO       = a_q;
    assign Fpu_B_DO       = b_q;
    assign Resp_Result_DO = res_q;
    assign Resp_Flags_DO  = flg_q;
    assign Resp_Tag_DO    = tag_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl with a timing-accurate fpu_core stub and a response scoreboard.
// Stub answers only in the cycle the real core would present its result.
// Responses are popped from the expected queue on each Resp_Valid & Resp_Ready.
module tb_fpu_issue_ctrl;
    import fpu_defs::*;

    localparam int TW = 4;

    logic          Clk_CI = 1'b0;
    logic          Rst_RBI;
    logic          Req_Valid_SI, Req_Ready_SO;
    logic [3:0]    Req_Op_SI;
    logic [2:0]    Req_RM_SI;
    logic [31:0]   Req_A_DI, Req_B_DI;
    logic [TW-1:0] Req_Tag_DI;
    logic          Resp_Valid_SO, Resp_Ready_SI;
    logic [31:0]   Resp_Result_DO;
    logic [5:0]    Resp_Flags_DO;
    logic [TW-1:0] Resp_Tag_DO;
    logic          Flush_SI, Flags_Clr_SI;
    logic [4:0]    Fflags_DO;
    logic          Fpu_Enable_SO, Fpu_Stall_SO;
    logic [3:0]    Fpu_Op_SO;
    logic [2:0]    Fpu_RM_SO;
    logic [31:0]   Fpu_A_DO, Fpu_B_DO;
    logic [31:0]   Fpu_Result_DI;
    logic [5:0]    Fpu_Flags_DI;

    typedef struct packed {
        logic [31:0]   res;
        logic [5:0]    flg;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic fpu_win;

    always #5 Clk_CI = ~Clk_CI;
    always @(posedge Clk_CI) cyc <= cyc + 1;

    fpu_issue_ctrl #(.TAG_WIDTH(TW)) dut (
        .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
        .Req_Valid_SI(Req_Valid_SI), .Req_Ready_SO(Req_Ready_SO),
        .Req_Op_SI(Req_Op_SI), .Req_RM_SI(Req_RM_SI),
        .Req_A_DI(Req_A_DI), .Req_B_DI(Req_B_DI), .Req_Tag_DI(Req_Tag_DI),
        .Resp_Valid_SO(Resp_Valid_SO), .Resp_Ready_SI(Resp_Ready_SI),
        .Resp_Result_DO(Resp_Result_DO), .Resp_Flags_DO(Resp_Flags_DO),
        .Resp_Tag_DO(Resp_Tag_DO), .Flush_SI(Flush_SI), .Flags_Clr_SI(Flags_Clr_SI),
        .Fflags_DO(Fflags_DO), .Fpu_Enable_SO(Fpu_Enable_SO), .Fpu_Stall_SO(Fpu_Stall_SO),
        .Fpu_Op_SO(Fpu_Op_SO), .Fpu_RM_SO(Fpu_RM_SO), .Fpu_A_DO(Fpu_A_DO), .Fpu_B_DO(Fpu_B_DO),
        .Fpu_Result_DI(Fpu_Result_DI), .Fpu_Flags_DI(Fpu_Flags_DI)
    );

    // fpu_core stub: known vectors, valid only in the real capture cycle, garbage otherwise.
    always_comb begin
        fpu_win       = Fpu_Enable_SO && ((Fpu_Op_SO == C_FPU_F2I_CMD) ? !Fpu_Stall_SO : Fpu_Stall_SO);
        Fpu_Result_DI = 32'hDEAD_BEEF;
        Fpu_Flags_DI  = 6'h3F;
        if (fpu_win) begin
            Fpu_Result_DI = 32'hBAD0_BAD0;
            Fpu_Flags_DI  = 6'b000001;
            if (Fpu_Op_SO == C_FPU_ADD_CMD && Fpu_A_DO == 32'h3F80_0000 && Fpu_B_DO == 32'h4000_0000) begin
                Fpu_Result_DI = 32'h4040_0000; Fpu_Flags_DI = 6'b000000;
            end else if (Fpu_Op_SO == C_FPU_SUB_CMD && Fpu_A_DO == 32'h4040_0000 && Fpu_B_DO == 32'h3F80_0000) begin
                Fpu_Result_DI = 32'h4000_0000; Fpu_Flags_DI = 6'b000000;
            end else if (Fpu_Op_SO == C_FPU_MUL_CMD && Fpu_A_DO == 32'h7F00_0000 && Fpu_B_DO == 32'h7F00_0000) begin
                Fpu_Result_DI = 32'h7F80_0000; Fpu_Flags_DI = 6'b010110;
            end else if (Fpu_Op_SO == C_FPU_F2I_CMD && Fpu_A_DO == 32'h4049_0FDB && Fpu_RM_SO == C_RM_TRUNC) begin
                Fpu_Result_DI = 32'h0000_0003; Fpu_Flags_DI = 6'b000100;
            end
        end
    end

    // Scoreboard: compare every handshaked response against the oldest expectation.
    always @(negedge Clk_CI) begin
        if (Rst_RBI && Resp_Valid_SO && Resp_Ready_SI) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_resp: got res=%h flg=%b tag=%0d, required no response",
                         Resp_Result_DO, Resp_Flags_DO, Resp_Tag_DO);
            end else begin
                mon_e = sb_q.pop_front();
                if ({Resp_Result_DO, Resp_Flags_DO, Resp_Tag_DO} !== mon_e) begin
                    n_bad++;
                    $display("FAIL resp_data: got res=%h flg=%b tag=%0d, required res=%h flg=%b tag=%0d",
                             Resp_Result_DO, Resp_Flags_DO, Resp_Tag_DO, mon_e.res, mon_e.flg, mon_e.tag);
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk_CI); #1;
    endtask

    // Present one request until accepted; returns the accept cycle, or -1 on timeout.
    task automatic send(input logic [3:0] op, input logic [2:0] rm, input logic [31:0] a,
                        input logic [31:0] b, input logic [TW-1:0] tag, output int t_acc);
        Req_Valid_SI = 1'b1; Req_Op_SI = op; Req_RM_SI = rm;
        Req_A_DI = a; Req_B_DI = b; Req_Tag_DI = tag;
        t_acc = -1;
        for (int i = 0; i < 20 && t_acc < 0; i++) begin
            @(negedge Clk_CI);
            if (Req_Ready_SO) t_acc = cyc;
            @(posedge Clk_CI); #1;
        end
        Req_Valid_SI = 1'b0;
        if (t_acc < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got no accept in 20 cycles, required accept (tag %0d)", tag);
        end
    endtask

    task automatic test_reset();
        Rst_RBI = 1'b0;
        step(); step();
        n_cmp++; if (Resp_Valid_SO !== 1'b0) begin n_bad++; $display("FAIL rst_resp_vld: got %b required 0", Resp_Valid_SO); end
        n_cmp++; if (Fpu_Enable_SO !== 1'b0) begin n_bad++; $display("FAIL rst_enable: got %b required 0", Fpu_Enable_SO); end
        n_cmp++; if (Fpu_Stall_SO !== 1'b1) begin n_bad++; $display("FAIL rst_stall: got %b required 1", Fpu_Stall_SO); end
        n_cmp++; if (Fflags_DO !== 5'b0) begin n_bad++; $display("FAIL rst_fflags: got %b required 00000", Fflags_DO); end
        n_cmp++; if ({Fpu_Op_SO, Fpu_A_DO, Resp_Result_DO} !== '0) begin n_bad++; $display("FAIL rst_regs: got op=%h a=%h res=%h required 0", Fpu_Op_SO, Fpu_A_DO, Resp_Result_DO); end
        Rst_RBI = 1'b1;
        step();
        n_cmp++; if (Req_Ready_SO !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b required 1", Req_Ready_SO); end
    endtask

    task automatic test_add();
        int t;
        Resp_Ready_SI = 1'b1;
        sb_q.push_back('{res: 32'h4040_0000, flg: 6'b000000, tag: 4'd5});
        send(C_FPU_ADD_CMD, C_RM_NEAREST, 32'h3F80_0000, 32'h4000_0000, 4'd5, t);
        n_cmp++; if ({Fpu_Enable_SO, Fpu_Stall_SO, Resp_Valid_SO} !== 3'b100) begin n_bad++; $display("FAIL add_issue: got en/stall/vld=%b required 100", {Fpu_Enable_SO, Fpu_Stall_SO, Resp_Valid_SO}); end
        n_cmp++; if ({Fpu_Op_SO, Fpu_A_DO, Fpu_B_DO} !== {C_FPU_ADD_CMD, 32'h3F80_0000, 32'h4000_0000}) begin n_bad++; $display("FAIL add_operands: got op=%h a=%h b=%h", Fpu_Op_SO, Fpu_A_DO, Fpu_B_DO); end
        step();
        n_cmp++; if ({Fpu_Enable_SO, Fpu_Stall_SO, Resp_Valid_SO} !== 3'b110) begin n_bad++; $display("FAIL add_norm: got en/stall/vld=%b required 110", {Fpu_Enable_SO, Fpu_Stall_SO, Resp_Valid_SO}); end
        step();
        n_cmp++; if (!(Resp_Valid_SO === 1'b1 && cyc - t == 3)) begin n_bad++; $display("FAIL add_latency: got vld=%b at T+%0d, required 1 at T+3", Resp_Valid_SO, cyc - t); end
        n_cmp++; if (Fpu_Enable_SO !== 1'b0) begin n_bad++; $display("FAIL add_resp_enable: got %b required 0", Fpu_Enable_SO); end
        step();
        n_cmp++; if ({Resp_Valid_SO, Req_Ready_SO, Fflags_DO} !== {2'b01, 5'b00000}) begin n_bad++; $display("FAIL add_after: got vld=%b rdy=%b fflags=%b required 0 1 00000", Resp_Valid_SO, Req_Ready_SO, Fflags_DO); end
    endtask

    task automatic test_f2i();
        int t;
        sb_q.push_back('{res: 32'h0000_0003, flg: 6'b000100, tag: 4'd6});
        send(C_FPU_F2I_CMD, C_RM_TRUNC, 32'h4049_0FDB, 32'h0, 4'd6, t);
        n_cmp++; if ({Fpu_Enable_SO, Fpu_Stall_SO, Resp_Valid_SO} !== 3'b100) begin n_bad++; $display("FAIL f2i_issue: got en/stall/vld=%b required 100", {Fpu_Enable_SO, Fpu_Stall_SO, Resp_Valid_SO}); end
        step();
        n_cmp++; if (!(Resp_Valid_SO === 1'b1 && cyc - t == 2)) begin n_bad++; $display("FAIL f2i_latency: got vld=%b at T+%0d, required 1 at T+2", Resp_Valid_SO, cyc - t); end
        step();
        n_cmp++; if (Fflags_DO !== 5'b00001) begin n_bad++; $display("FAIL f2i_fflags: got %b required 00001", Fflags_DO); end
    endtask

    task automatic test_illegal();
        int t;
        sb_q.push_back('{res: 32'h0, flg: 6'b100000, tag: 4'd2});
        send(C_FPU_DIV_CMD, C_RM_NEAREST, 32'h3F80_0000, 32'h3F80_0000, 4'd2, t);
        n_cmp++; if (!(Resp_Valid_SO === 1'b1 && cyc - t == 1)) begin n_bad++; $display("FAIL ill_latency: got vld=%b at T+%0d, required 1 at T+1", Resp_Valid_SO, cyc - t); end
        n_cmp++; if (Fpu_Enable_SO !== 1'b0) begin n_bad++; $display("FAIL ill_enable_resp: got %b required 0", Fpu_Enable_SO); end
        step();
        n_cmp++; if (Fpu_Enable_SO !== 1'b0) begin n_bad++; $display("FAIL ill_enable_after: got %b required 0", Fpu_Enable_SO); end
        n_cmp++; if (Fflags_DO !== 5'b10001) begin n_bad++; $display("FAIL ill_fflags: got %b required 10001", Fflags_DO); end
    endtask

    task automatic test_mul_hold();
        int t;
        Resp_Ready_SI = 1'b0;
        sb_q.push_back('{res: 32'h7F80_0000, flg: 6'b010110, tag: 4'd9});
        send(C_FPU_MUL_CMD, C_RM_NEAREST, 32'h7F00_0000, 32'h7F00_0000, 4'd9, t);
        step();
        Flags_Clr_SI = 1'b1;
        n_cmp++; if ({Fpu_Enable_SO, Fpu_Stall_SO} !== 2'b11) begin n_bad++; $display("FAIL mul_norm: got en/stall=%b required 11", {Fpu_Enable_SO, Fpu_Stall_SO}); end
        step();
        Flags_Clr_SI = 1'b0;
        n_cmp++; if (Fflags_DO !== 5'b00101) begin n_bad++; $display("FAIL mul_clr_set: got %b required 00101", Fflags_DO); end
        Req_Valid_SI = 1'b1; Req_Op_SI = C_FPU_ADD_CMD; Req_Tag_DI = 4'd3;
        Req_A_DI = 32'h3F80_0000; Req_B_DI = 32'h4000_0000;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({Resp_Valid_SO, Req_Ready_SO, Resp_Result_DO, Resp_Flags_DO, Resp_Tag_DO} !==
                {2'b10, 32'h7F80_0000, 6'b010110, 4'd9}) begin
                n_bad++;
                $display("FAIL mul_hold[%0d]: got vld=%b rdy=%b res=%h flg=%b tag=%0d required 1 0 7f800000 010110 9",
                         i, Resp_Valid_SO, Req_Ready_SO, Resp_Result_DO, Resp_Flags_DO, Resp_Tag_DO);
            end
            step();
        end
        Req_Valid_SI = 1'b0;
        Resp_Ready_SI = 1'b1;
        step();
        n_cmp++; if (Resp_Valid_SO !== 1'b0) begin n_bad++; $display("FAIL mul_drained: got vld=%b required 0", Resp_Valid_SO); end
    endtask

    task automatic test_flush();
        int t;
        int w;
        send(C_FPU_ADD_CMD, C_RM_NEAREST, 32'h3F80_0000, 32'h4000_0000, 4'd7, t);
        step();
        Flush_SI = 1'b1;
        Req_Valid_SI = 1'b1; Req_Op_SI = C_FPU_SUB_CMD; Req_Tag_DI = 4'd8;
        Req_A_DI = 32'h4040_0000; Req_B_DI = 32'h3F80_0000;
        #1;
        n_cmp++; if (Req_Ready_SO !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b required 0", Req_Ready_SO); end
        step();
        Flush_SI = 1'b0; Req_Valid_SI = 1'b0;
        n_cmp++; if ({Resp_Valid_SO, Fpu_Enable_SO} !== 2'b00) begin n_bad++; $display("FAIL flush_after: got vld/en=%b required 00", {Resp_Valid_SO, Fpu_Enable_SO}); end
        n_cmp++; if (Fflags_DO !== 5'b00101) begin n_bad++; $display("FAIL flush_fflags: got %b required 00101", Fflags_DO); end
        sb_q.push_back('{res: 32'h4000_0000, flg: 6'b000000, tag: 4'd8});
        send(C_FPU_SUB_CMD, C_RM_NEAREST, 32'h4040_0000, 32'h3F80_0000, 4'd8, t);
        w = 0;
        while (Resp_Valid_SO !== 1'b1 && w < 10) begin step(); w++; end
        n_cmp++; if (cyc - t != 3) begin n_bad++; $display("FAIL sub_latency: got T+%0d required T+3", cyc - t); end
        step();
    endtask

    task automatic test_back_to_back();
        int ta[3];
        Resp_Ready_SI = 1'b1;
        Req_Valid_SI = 1'b1; Req_Op_SI = C_FPU_ADD_CMD; Req_RM_SI = C_RM_NEAREST;
        Req_A_DI = 32'h3F80_0000; Req_B_DI = 32'h4000_0000;
        for (int n = 0; n < 3; n++) begin
            Req_Tag_DI = 4'(n + 10);
            sb_q.push_back('{res: 32'h4040_0000, flg: 6'b000000, tag: 4'(n + 10)});
            ta[n] = -100;
            for (int i = 0; i < 10 && ta[n] < 0; i++) begin
                @(negedge Clk_CI);
                if (Req_Ready_SO) ta[n] = cyc;
                @(posedge Clk_CI); #1;
            end
        end
        Req_Valid_SI = 1'b0;
        n_cmp++; if (ta[1] - ta[0] != 3) begin n_bad++; $display("FAIL b2b_gap01: got %0d required 3", ta[1] - ta[0]); end
        n_cmp++; if (ta[2] - ta[1] != 3) begin n_bad++; $display("FAIL b2b_gap12: got %0d required 3", ta[2] - ta[1]); end
        repeat (4) step();
    endtask

    task automatic test_reset_mid();
        int t;
        sb_q.push_back('{res: 32'h4040_0000, flg: 6'b000000, tag: 4'd11});
        send(C_FPU_ADD_CMD, C_RM_NEAREST, 32'h3F80_0000, 32'h4000_0000, 4'd11, t);
        #2 Rst_RBI = 1'b0;
        #3 Rst_RBI = 1'b1;
        step();
        n_cmp++; if ({Fpu_Enable_SO, Fpu_Stall_SO} !== 2'b11) begin n_bad++; $display("FAIL rst_glitch: got en/stall=%b required 11", {Fpu_Enable_SO, Fpu_Stall_SO}); end
        step(); step();
        send(C_FPU_ADD_CMD, C_RM_NEAREST, 32'h3F80_0000, 32'h4000_0000, 4'd12, t);
        Rst_RBI = 1'b0;
        step();
        n_cmp++;
        if ({Resp_Valid_SO, Fflags_DO, Fpu_Stall_SO, Fpu_Enable_SO} !== {1'b0, 5'b00000, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_mid: got vld=%b fflags=%b stall=%b en=%b required 0 00000 1 0",
                     Resp_Valid_SO, Fflags_DO, Fpu_Stall_SO, Fpu_Enable_SO);
        end
        Rst_RBI = 1'b1;
        repeat (5) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required earlier finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_RBI = 1'b0; Req_Valid_SI = 1'b0; Req_Op_SI = '0; Req_RM_SI = '0;
        Req_A_DI = '0; Req_B_DI = '0; Req_Tag_DI = '0; Resp_Ready_SI = 1'b0;
        Flush_SI = 1'b0; Flags_Clr_SI = 1'b0;
        test_reset();
        test_add();
        test_f2i();
        test_illegal();
        test_mul_hold();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d responses outstanding, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
